// File: rtl/fpu_bus_if.sv
// fpu_bus_if: CPU-bus register front end for the fpu core.
// Operands are loaded byte-wise and one command is issued at a time.
// The result is latched when the core completes. Completion, timeout
// and rejected writes are reported through sticky flags and a
// maskable level interrupt.

package pa_fpu;
  typedef enum logic [3:0] {
    FPU_ADD  = 4'd0,
    FPU_SUB  = 4'd1,
    FPU_MUL  = 4'd2,
    FPU_DIV  = 4'd3,
    FPU_SQRT = 4'd4,
    FPU_CMP  = 4'd5,
    FPU_F2I  = 4'd6,
    FPU_I2F  = 4'd7
  } e_fpu_op;
endpackage

module fpu_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [3:0]      bus_addr,
  input  logic [7:0]      bus_data_in,
  input  logic            bus_wr,
  input  logic            bus_rd,
  output logic [7:0]      bus_data_out,
  output logic [31:0]     fpu_a_operand,
  output logic [31:0]     fpu_b_operand,
  output pa_fpu::e_fpu_op fpu_operation,
  output logic            fpu_start,
  input  logic [31:0]     fpu_result,
  input  logic            fpu_cmd_end,
  input  logic            fpu_busy,
  output logic            irq
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     a_q, b_q, res_q;
  pa_fpu::e_fpu_op op_q;
  logic [15:0]     cnt_q;
  logic            done_q, tmo_q, rej_q, irqen_q;
  logic            busy, cap_ev, tmo_ev, tmo_hit;
  logic            wr_ab, wr_cmd, wr_st, go_wr, rej_ev;
  logic [7:0]      clr, status, rd_mux;
  logic [4:0]      bsel;
  logic            unused_data_bits;

  // Data bits 6:4 have no meaning in CMD or STATUS.
  assign unused_data_bits = ^bus_data_in[6:4];

  assign bsel    = {bus_addr[1:0], 3'b000};
  assign wr_ab   = bus_wr && (bus_addr < 4'd8);
  assign wr_cmd  = bus_wr && (bus_addr == 4'd12);
  assign wr_st   = bus_wr && (bus_addr == 4'd13);
  assign rej_ev  = busy && (wr_ab || wr_cmd);
  assign go_wr   = wr_cmd && !busy && bus_data_in[7];
  assign tmo_hit = (cnt_q == TO_LAST);
  assign clr     = wr_st ? bus_data_in : 8'h00;
  assign status  = {irqen_q, 3'b000, rej_q, tmo_q, done_q, busy};

  // Command sequencer state register.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: cmd_end has priority over an expiring watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (go_wr) state_d = S_ISSUE;
      S_ISSUE:   if (fpu_cmd_end) state_d = S_CAPTURE;
                 else if (tmo_hit) state_d = S_IDLE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs and event strobes. start is decoded from state,
  // so it follows an asynchronous reset immediately.
  always_comb begin
    fpu_start = 1'b0;
    cap_ev    = 1'b0;
    tmo_ev    = 1'b0;
    busy      = fpu_busy;
    if (state_q == S_ISSUE) begin
      fpu_start = 1'b1;
      tmo_ev    = !fpu_cmd_end && tmo_hit;
    end
    if (state_q == S_CAPTURE) cap_ev = 1'b1;
    if (state_q != S_IDLE) busy = 1'b1;
  end

  // Operand, op and result registers; A/B/CMD are frozen while busy.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      op_q  <= pa_fpu::FPU_ADD;
    end else begin
      if (wr_ab && !busy) begin
        if (!bus_addr[2]) a_q[bsel +: 8] <= bus_data_in;
        else              b_q[bsel +: 8] <= bus_data_in;
      end
      if (wr_cmd && !busy) op_q <= pa_fpu::e_fpu_op'(bus_data_in[3:0]);
      if (cap_ev) res_q <= fpu_result;
    end
  end

  // Watchdog: cleared on issue, counts in ISSUE, saturates at 16 bits.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)                                         cnt_q <= '0;
    else if (go_wr)                                    cnt_q <= '0;
    else if (state_q == S_ISSUE && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  // Sticky flags: W1C, with a same-edge set winning over the clear.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rej_q   <= 1'b0;
      irqen_q <= 1'b0;
    end else begin
      done_q  <= (done_q & ~clr[1]) | cap_ev | tmo_ev;
      tmo_q   <= (tmo_q  & ~clr[2]) | tmo_ev;
      rej_q   <= (rej_q  & ~clr[3]) | rej_ev;
      irqen_q <= wr_st ? bus_data_in[7] : irqen_q;
    end
  end

  // Read mux over the pre-write register contents.
  always_comb begin
    rd_mux = 8'h00;
    case (bus_addr[3:2])
      2'd0:    rd_mux = a_q[bsel +: 8];
      2'd1:    rd_mux = b_q[bsel +: 8];
      2'd2:    rd_mux = res_q[bsel +: 8];
      default: if (bus_addr == 4'd13) rd_mux = status;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)       bus_data_out <= 8'h00;
    else if (bus_rd) bus_data_out <= rd_mux;
  end

  assign fpu_a_operand = a_q;
  assign fpu_b_operand = b_q;
  assign fpu_operation = op_q;
  assign irq           = irqen_q & (done_q | tmo_q | rej_q);

endmodule

// File: tb/tb_fpu_bus_if.sv
// Bench for fpu_bus_if: stub fpu core, transaction-level register model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fpu_bus_if;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            arst;
  logic [3:0]      bus_addr = '0;
  logic [7:0]      bus_data_in = '0;
  logic            bus_wr = 1'b0;
  logic            bus_rd = 1'b0;
  logic [7:0]      bus_data_out;
  logic [31:0]     fpu_a_operand, fpu_b_operand;
  pa_fpu::e_fpu_op fpu_operation;
  logic            fpu_start;
  logic [31:0]     fpu_result = 32'h4096FC2A;
  logic            fpu_cmd_end;
  logic            fpu_busy = 1'b0;
  logic            irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_bus_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .arst(arst), .bus_addr(bus_addr), .bus_data_in(bus_data_in),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_data_out(bus_data_out),
    .fpu_a_operand(fpu_a_operand), .fpu_b_operand(fpu_b_operand),
    .fpu_operation(fpu_operation), .fpu_start(fpu_start),
    .fpu_result(fpu_result), .fpu_cmd_end(fpu_cmd_end),
    .fpu_busy(fpu_busy), .irq(irq)
  );

  // Stub core: one-cycle cmd_end pulse after start has been high stub_lat cycles.
  int stub_lat = 5;
  bit stub_never = 1'b0;
  int stub_cnt;
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      stub_cnt    <= 0;
      fpu_cmd_end <= 1'b0;
    end else begin
      stub_cnt    <= fpu_start ? stub_cnt + 1 : 0;
      fpu_cmd_end <= fpu_start && !stub_never && (stub_cnt == stub_lat - 1);
    end
  end

  // Running count of cycles with start high.
  int start_total = 0;
  always @(posedge clk) if (fpu_start === 1'b1) start_total <= start_total + 1;

  // Register-level model: phase 0 idle, 1 command running, 2 result pending.
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic [7:0]  m_rdata;
  bit          m_done, m_tmo, m_rej, m_ien;
  int          m_phase, m_age;

  function automatic logic [7:0] mread(input logic [3:0] ad, input bit bsy);
    int o;
    o = 8 * int'(ad[1:0]);
    if (ad < 4'd4)       return 8'(m_a >> o);
    else if (ad < 4'd8)  return 8'(m_b >> o);
    else if (ad < 4'd12) return 8'(m_res >> o);
    else if (ad == 4'd13) return {m_ien, 3'b000, m_rej, m_tmo, m_done, bsy};
    return 8'h00;
  endfunction

  always @(posedge clk or negedge arst) begin
    bit mbusy, s_done, s_tmo, s_rej;
    if (!arst) begin
      m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_rdata = '0;
      m_done = 0; m_tmo = 0; m_rej = 0; m_ien = 0; m_phase = 0; m_age = 0;
    end else begin
      mbusy = (m_phase != 0) || fpu_busy;
      s_done = 0; s_tmo = 0; s_rej = 0;
      if (bus_rd) m_rdata = mread(bus_addr, mbusy);
      if (m_phase == 1) begin
        if (fpu_cmd_end) m_phase = 2;
        else begin
          m_age++;
          if (m_age == TO) begin m_phase = 0; s_done = 1; s_tmo = 1; end
        end
      end else if (m_phase == 2) begin
        m_res = fpu_result; s_done = 1; m_phase = 0;
      end
      if (bus_wr) begin
        if ((bus_addr < 4'd8 || bus_addr == 4'd12) && mbusy) s_rej = 1;
        else if (bus_addr < 4'd4) m_a[8*int'(bus_addr[1:0]) +: 8] = bus_data_in;
        else if (bus_addr < 4'd8) m_b[8*int'(bus_addr[1:0]) +: 8] = bus_data_in;
        else if (bus_addr == 4'd12) begin
          m_op = bus_data_in[3:0];
          if (bus_data_in[7]) begin m_phase = 1; m_age = 0; end
        end
        if (bus_addr == 4'd13) begin
          if (bus_data_in[1]) m_done = 0;
          if (bus_data_in[2]) m_tmo = 0;
          if (bus_data_in[3]) m_rej = 0;
          m_ien = bus_data_in[7];
        end
      end
      m_done |= s_done; m_tmo |= s_tmo; m_rej |= s_rej;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) if (arst === 1'b1) begin
    chk("m_start", 32'(fpu_start), 32'(m_phase == 1));
    chk("m_a_op", fpu_a_operand, m_a);
    chk("m_b_op", fpu_b_operand, m_b);
    chk("m_op", 32'(fpu_operation), 32'(m_op));
    chk("m_irq", 32'(irq), 32'(m_ien & (m_done | m_tmo | m_rej)));
    chk("m_rdata", 32'(bus_data_out), 32'(m_rdata));
  end

  task automatic wr(input logic [3:0] ad, input logic [7:0] d);
    bus_addr = ad; bus_data_in = d; bus_wr = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ad, input logic [7:0] exp, input string nm);
    bus_addr = ad; bus_rd = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0;
    chk(nm, 32'(bus_data_out), 32'(exp));
  endtask

  task automatic wait_cmd_end(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (fpu_cmd_end === 1'b1) return;
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL %s: cmd_end not seen within 40 cycles", nm);
  endtask

  int s0;

  initial begin
    arst = 1'b1;
    #1 arst = 1'b0;
    #2;
    chk("rst_start", 32'(fpu_start), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", 32'(bus_data_out), 32'd0);
    @(negedge clk); @(negedge clk);
    arst = 1'b1;
    @(negedge clk);

    // Byte-wise add
    wr(0, 8'hFF); wr(1, 8'hFF); wr(2, 8'hFF); wr(3, 8'h3F);
    wr(4, 8'h54); wr(5, 8'hF8); wr(6, 8'h2D); wr(7, 8'h40);
    chk("a_loaded", fpu_a_operand, 32'h3FFFFFFF);
    chk("b_loaded", fpu_b_operand, 32'h402DF854);
    s0 = start_total;
    wr(12, 8'h80);
    repeat (10) @(negedge clk);
    chk("add_start_len", 32'(start_total - s0), 32'd6);
    rd(8, 8'h2A, "res_b0"); rd(9, 8'hFC, "res_b1");
    rd(10, 8'h96, "res_b2"); rd(11, 8'h40, "res_b3");
    rd(13, 8'h02, "status_after_add");

    // IRQ path
    wr(13, 8'h82);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd(13, 8'h80, "status_ien_only");
    fpu_result = 32'h40490FDB; stub_lat = 3;
    wr(12, 8'h82);
    wait_cmd_end("irq_cmd");
    chk("irq_at_cmd_end", 32'(irq), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("irq_after_capture", 32'(irq), 32'd1);
    rd(8, 8'hDB, "mul_res_b0");
    wr(13, 8'h82);
    chk("irq_w1c", 32'(irq), 32'd0);
    rd(13, 8'h80, "ien_kept");

    // Reject while issuing
    fpu_result = 32'h4096FC2A; stub_lat = 5;
    wr(12, 8'h80);
    wr(0, 8'h12);
    repeat (10) @(negedge clk);
    chk("a_unchanged", fpu_a_operand, 32'h3FFFFFFF);
    rd(0, 8'hFF, "a_b0_kept");
    rd(13, 8'h8A, "status_reject");
    chk("irq_reject", 32'(irq), 32'd1);
    wr(13, 8'h0E);
    rd(13, 8'h00, "status_cleared");

    // Watchdog timeout
    stub_never = 1'b1;
    s0 = start_total;
    wr(12, 8'h80);
    repeat (12) @(negedge clk);
    chk("to_start_len", 32'(start_total - s0), 32'd8);
    rd(13, 8'h06, "status_timeout");
    rd(8, 8'h2A, "res_kept_b0"); rd(11, 8'h40, "res_kept_b3");
    stub_never = 1'b0;
    wr(13, 8'h06);

    // Clear of DONE on the capture edge loses to the set
    wr(12, 8'h80);
    wait_cmd_end("clrset_cmd");
    @(negedge clk);
    wr(13, 8'h02);
    rd(13, 8'h02, "done_set_wins");
    wr(13, 8'h02);

    // External core busy blocks writes while idle
    fpu_busy = 1'b1;
    wr(0, 8'h55);
    rd(13, 8'h09, "status_core_busy");
    fpu_busy = 1'b0;
    rd(0, 8'hFF, "a_b0_core_busy");
    wr(13, 8'h08);

    // Read and write on the same cycle return the old byte
    bus_addr = 4'd4; bus_data_in = 8'h99; bus_wr = 1'b1; bus_rd = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0; bus_rd = 1'b0;
    chk("rdwr_old", 32'(bus_data_out), 32'h54);
    rd(4, 8'h99, "rdwr_new");
    chk("b_after_rdwr", fpu_b_operand, 32'h402DF899);

    // Reset in the middle of a command
    stub_never = 1'b1;
    wr(13, 8'h80);
    wr(12, 8'h80);
    wr(0, 8'h77);
    rd(4, 8'h99, "pre_rst_rd");
    chk("pre_rst_start", 32'(fpu_start), 32'd1);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    #2 arst = 1'b0;
    #1;
    chk("midrst_start", 32'(fpu_start), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_rdata", 32'(bus_data_out), 32'd0);
    @(negedge clk);
    arst = 1'b1;
    stub_never = 1'b0;
    rd(0, 8'h00, "post_rst_a");
    rd(4, 8'h00, "post_rst_b");
    rd(8, 8'h00, "post_rst_res");
    rd(13, 8'h00, "post_rst_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
